// File: rtl/mac_pkg.sv
// Shared state type and signed saturation helper for the signed MAC pipeline.
package mac_pkg;

  typedef enum logic [1:0] {
    MAC_IDLE,
    MAC_ACCUM,
    MAC_HOLD
  } mac_state_t;

  // Working width for the clamp helper; callers sign-extend into it.
  localparam int SAT_CALC_W = 64;

  // Clamp a signed value to the range of an n-bit signed integer.
  function automatic logic signed [SAT_CALC_W-1:0] sat_clamp(
    input logic signed [SAT_CALC_W-1:0] x,
    input int unsigned                  n
  );
    logic signed [SAT_CALC_W-1:0] max_v;
    logic signed [SAT_CALC_W-1:0] min_v;
    max_v = (64'sd1 <<< (n - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (x > max_v)      sat_clamp = max_v;
    else if (x < min_v) sat_clamp = min_v;
    else                sat_clamp = x;
  endfunction

endpackage

// File: rtl/sat_scale.sv
// Combinational accumulator-to-output scaling: arithmetic shift, then signed saturation.
// MAC_ROUND_EN defined: round-half-up before the shift; undefined: plain truncating shift.
module sat_scale
  import mac_pkg::*;
#(
  parameter int ACC_W     = 16,
  parameter int OUT_W     = 8,
  parameter int OUT_SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] data,
  output logic                    sat
);

  localparam int WIDE_W = ACC_W + 1;

`ifdef MAC_ROUND_EN
  localparam int BIAS_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  // Half an output LSB; zero when there is no shift, so rounding degenerates cleanly.
  localparam logic signed [WIDE_W-1:0] BIAS =
    (OUT_SHIFT > 0) ? WIDE_W'(1 << BIAS_POS) : '0;
`else
  localparam logic signed [WIDE_W-1:0] BIAS = '0;
`endif

  logic signed [WIDE_W-1:0]     biased;
  logic signed [WIDE_W-1:0]     shifted;
  logic signed [SAT_CALC_W-1:0] clamped;

  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    biased  = WIDE_W'(acc) + BIAS;
    shifted = biased >>> OUT_SHIFT;
    clamped = sat_clamp(SAT_CALC_W'(shifted), OUT_W);
    data    = OUT_W'(clamped);
    sat     = (clamped != SAT_CALC_W'(shifted));
  end

endmodule

// File: rtl/signed_mac_pipe.sv
// Pipelined signed multiply-accumulate: registered product stage, saturating accumulator FSM,
// scaled/saturated result held under backpressure. Output rounding selected by MAC_ROUND_EN.
module signed_mac_pipe
  import mac_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16,  // at least 2*DATA_W so a single product never saturates
  parameter int OUT_W     = 8,   // at most ACC_W
  parameter int OUT_SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] weight,
  input  logic signed [DATA_W-1:0] value,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_overflow,
  output logic                     busy
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = ACC_W + 1;

  mac_state_t state;
  mac_state_t state_nxt;

  logic                         s1_valid;
  logic                         s1_last;
  logic signed [PROD_W-1:0]     s1_prod;

  logic signed [ACC_W-1:0]      acc;
  logic signed [ACC_W-1:0]      acc_nxt;
  logic signed [ACC_W-1:0]      acc_base;
  logic signed [ACC_W-1:0]      acc_sat;
  logic signed [SUM_W-1:0]      sum;
  logic signed [SAT_CALC_W-1:0] sum_clamped;
  logic                         sum_ovf;
  logic                         sticky;
  logic                         sticky_nxt;
  logic                         sticky_base;

  logic                         stall;
  logic signed [OUT_W-1:0]      scaled;
  logic                         scale_sat;

  assign out_valid = (state == MAC_HOLD);
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign busy      = (state != MAC_IDLE) | s1_valid;

  // Stage 1: exact full-width product; frozen while the held result is not taken.
  // NOTE: registered state is assigned with non-blocking <= so all flops update together at the edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_last  <= in_last;
      s1_prod  <= PROD_W'(weight) * PROD_W'(value);
    end
  end

  // Stage 2 datapath. A beat consumed while holding a result starts a fresh vector.
  always_comb begin
    acc_base    = (state == MAC_HOLD) ? '0 : acc;
    sticky_base = (state == MAC_HOLD) ? 1'b0 : sticky;
    sum         = SUM_W'(acc_base) + SUM_W'(s1_prod);
    sum_clamped = sat_clamp(SAT_CALC_W'(sum), ACC_W);
    acc_sat     = ACC_W'(sum_clamped);
    sum_ovf     = (sum_clamped != SAT_CALC_W'(sum));
  end

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    sticky_nxt = sticky;
    case (state)
      MAC_IDLE, MAC_ACCUM: begin
        if (s1_valid) begin
          acc_nxt    = acc_sat;
          sticky_nxt = sticky_base | sum_ovf;
          state_nxt  = s1_last ? MAC_HOLD : MAC_ACCUM;
        end
      end
      MAC_HOLD: begin
        if (out_ready) begin
          if (s1_valid) begin
            acc_nxt    = acc_sat;
            sticky_nxt = sticky_base | sum_ovf;
            state_nxt  = s1_last ? MAC_HOLD : MAC_ACCUM;
          end else begin
            acc_nxt    = '0;
            sticky_nxt = 1'b0;
            state_nxt  = MAC_IDLE;
          end
        end
      end
      default: begin
        acc_nxt    = '0;
        sticky_nxt = 1'b0;
        state_nxt  = MAC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= MAC_IDLE;
      acc    <= '0;
      sticky <= 1'b0;
    end else if (clear) begin
      state  <= MAC_IDLE;
      acc    <= '0;
      sticky <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      sticky <= sticky_nxt;
    end
  end

  sat_scale #(
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_sat_scale (
    .acc (acc),
    .data(scaled),
    .sat (scale_sat)
  );

  // Outputs read zero whenever no result is offered.
  assign out_data     = out_valid ? scaled : '0;
  assign out_overflow = out_valid & (sticky | scale_sat);

endmodule
